dtfag_index_seq: RTL and testbench

//  Request-side sequencer for the DTFAG twiddle generator: issues one
//  (DTFAG_i, DTFAG_t, DTFAG_j) index triple plus active-low ROM_CEN per cycle
//  for every radix-16 NTT stage of a 65536-point transform.

---
 rtl/dtfag_index_seq.sv | 193 +++++++++++++++++++
 tb/tb_dtfag_index_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtfag_index_seq.sv
// dtfag_index_seq
// Request-side sequencer for the DTFAG twiddle generator. It walks a 12-bit
// {i,t,j} index counter through the twiddle-bearing radix-16 stages of a
// 65536-point NTT. Stage 0 sweeps all 4096 triples, stage 1 holds i at 0
// (256 triples) and stage 2 holds i=t=0 (16 triples), for 4368 requests in
// total. The counter moves straight into the next stage with no bubble.
// Each issued request is tracked through the fixed AGU/ROM/multiplier
// latency so that tf_valid lines up with Process2_out0..15. A credit counter
// stops issue when the downstream twiddle FIFO has no free group slot.
//
// Optional feature (macro DTFAG_SEQ_BITREV_EN):
//   defined   : DTFAG_j is the bit-reversed j counter (0,8,4,12,...).
//   undefined : DTFAG_j is the j counter in natural order.
//   Counting, carries and tf_last are the same in both builds.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-high
//   start     1-cycle pulse, starts a sequence (ignored unless IDLE)
//   tf_pop    downstream FIFO popped one group (returns one credit)
//   DTFAG_i   index i to DTFAG
//   DTFAG_t   index t to DTFAG
//   DTFAG_j   index j to DTFAG
//   ROM_CEN   0 = request issued this cycle, 1 = idle
//   tf_valid  Process2_out0..15 valid this cycle
//   tf_stage  stage of the group on tf_valid
//   tf_last   group on tf_valid is the last one of its stage
//   busy      sequencer not IDLE
//   done      1-cycle pulse at end of sequence
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing one request per cycle while credit > 0
// DRAIN | last request issued, waiting LAT cycles for it to emerge
// DONE  | done pulse, back to IDLE next cycle

module dtfag_index_seq #(
   parameter int RADIX_W = 4,
   parameter int STAGES  = 4,
   parameter int LAT     = 3,
   parameter int CREDITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               tf_pop,
   output logic [RADIX_W-1:0] DTFAG_i,
   output logic [RADIX_W-1:0] DTFAG_t,
   output logic [RADIX_W-1:0] DTFAG_j,
   output logic               ROM_CEN,
   output logic               tf_valid,
   output logic [1:0]         tf_stage,
   output logic               tf_last,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = 3 * RADIX_W;
   localparam int CR_W  = $clog2(CREDITS + 1);
   localparam int DR_W  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [1:0]      LAST_STAGE = 2'(STAGES - 2);
   localparam logic [CR_W-1:0] CR_FULL    = CR_W'(CREDITS);
   localparam logic [DR_W-1:0] DR_LOAD    = DR_W'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        stage;
   logic [CR_W-1:0]   credit;
   logic [DR_W-1:0]   drain_cnt;
   logic [CNT_W-1:0]  cnt_limit;
   logic              at_limit;
   logic              issue;
   logic              pop_ok;
   logic              last_req;

   logic [LAT-1:0]    trk_v;
   logic [LAT-1:0]    trk_l;
   logic [1:0]        trk_s [LAT];

   // Later stages hold the upper indices at zero, so the wrap point is the
   // all-ones pattern shifted down one index per stage.
   always_comb begin
      cnt_limit = {CNT_W{1'b1}} >> (stage * RADIX_W);
      at_limit  = (cnt == cnt_limit);
      issue     = (state == S_RUN) && (credit != '0);
      pop_ok    = tf_pop && (credit != CR_FULL);
      last_req  = issue && at_limit && (stage == LAST_STAGE);
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_req) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      ROM_CEN = ~issue;
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
      DTFAG_i = cnt[CNT_W-1 -: RADIX_W];
      DTFAG_t = cnt[2*RADIX_W-1 -: RADIX_W];
`ifdef DTFAG_SEQ_BITREV_EN
      DTFAG_j = '0;
      for (int b = 0; b < RADIX_W; b++) DTFAG_j[b] = cnt[RADIX_W-1-b];
`else
      DTFAG_j = cnt[RADIX_W-1:0];
`endif
      tf_valid = trk_v[LAT-1];
      tf_stage = trk_s[LAT-1];
      tf_last  = trk_l[LAT-1];
   end

   // Index counter; it is also the index output register, so with no credit
   // the indices simply hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         stage <= '0;
      end else if (state == S_IDLE && start) begin
         cnt   <= '0;
         stage <= '0;
      end else if (issue) begin
         if (at_limit) begin
            cnt   <= '0;
            stage <= (stage == LAST_STAGE) ? 2'd0 : stage + 2'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Credit counter; pops at full credit are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit <= CR_FULL;
      end else begin
         unique case ({issue, pop_ok})
            2'b10:   credit <= credit - CR_W'(1);
            2'b01:   credit <= credit + CR_W'(1);
            default: credit <= credit;
         endcase
      end
   end

   // Drain timer: loaded with the last request, DONE follows LAT cycles later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    drain_cnt <= '0;
      else if (last_req)          drain_cnt <= DR_LOAD;
      else if (state == S_DRAIN && drain_cnt != '0)
                                  drain_cnt <= drain_cnt - DR_W'(1);
   end

   // Request tracking pipe; entry k is k+1 cycles old.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_v <= '0;
         trk_l <= '0;
         for (int k = 0; k < LAT; k++) trk_s[k] <= 2'd0;
      end else begin
         trk_v[0] <= issue;
         trk_l[0] <= issue && at_limit;
         trk_s[0] <= issue ? stage : 2'd0;
         for (int k = 1; k < LAT; k++) begin
            trk_v[k] <= trk_v[k-1];
            trk_l[k] <= trk_l[k-1];
            trk_s[k] <= trk_s[k-1];
         end
      end
   end

endmodule

// File: tb/tb_dtfag_index_seq.sv
module tb_dtfag_index_seq;

   localparam int LAT   = 3;
   localparam int TOTAL = 4368;

   logic       clk;
   logic       rst;
   logic       start;
   logic       tf_pop;
   logic [3:0] DTFAG_i;
   logic [3:0] DTFAG_t;
   logic [3:0] DTFAG_j;
   logic       ROM_CEN;
   logic       tf_valid;
   logic [1:0] tf_stage;
   logic       tf_last;
   logic       busy;
   logic       done;

   dtfag_index_seq dut (
      .clk(clk), .rst(rst), .start(start), .tf_pop(tf_pop),
      .DTFAG_i(DTFAG_i), .DTFAG_t(DTFAG_t), .DTFAG_j(DTFAG_j),
      .ROM_CEN(ROM_CEN), .tf_valid(tf_valid), .tf_stage(tf_stage),
      .tf_last(tf_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] i;
      logic [3:0] t;
      logic [3:0] j;
      logic [1:0] s;
      logic       l;
   } req_t;

   typedef struct {
      logic [1:0] s;
      logic       l;
      int         cyc;
   } trk_t;

   req_t exp_q[$];
   trk_t val_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_iss, n_val, n_done, n_last;
   int last_iss_cyc, done_cyc;
   int last_grp [3];
   logic [3:0] first_j [4];
   logic [11:0] first_trip, trip17;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] brev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic fill_exp();
      req_t e;
      int imax, tmax;
      logic [3:0] jv;
      exp_q.delete();
      for (int s = 0; s < 3; s++) begin
         imax = (s == 0) ? 15 : 0;
         tmax = (s <= 1) ? 15 : 0;
         for (int i = 0; i <= imax; i++)
            for (int t = 0; t <= tmax; t++)
               for (int j = 0; j < 16; j++) begin
                  jv  = 4'(j);
                  e.i = 4'(i);
                  e.t = 4'(t);
`ifdef DTFAG_SEQ_BITREV_EN
                  e.j = brev4(jv);
`else
                  e.j = jv;
`endif
                  e.s = 2'(s);
                  e.l = (i == imax) && (t == tmax) && (j == 15);
                  exp_q.push_back(e);
               end
      end
   endtask

   task automatic clear_run();
      n_iss = 0; n_val = 0; n_done = 0; n_last = 0;
      last_iss_cyc = 0; done_cyc = 0;
      for (int k = 0; k < 3; k++) last_grp[k] = 0;
      val_q.delete();
   endtask

   // Monitor: compares issued triples and returned groups against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (tf_valid) begin
            n_val++;
            if (val_q.size() == 0) begin
               chk("unexpected_tf_valid", 1, 0);
            end else begin
               trk_t v;
               v = val_q.pop_front();
               chk("tf_stage", int'(tf_stage), int'(v.s));
               chk("tf_last", int'(tf_last), int'(v.l));
               chk("tf_valid_latency", cyc - v.cyc, LAT);
            end
            if (tf_last && n_last < 3) begin
               last_grp[n_last] = n_val;
               n_last++;
            end
         end
         if (!ROM_CEN) begin
            if (n_iss < 4) first_j[n_iss] = DTFAG_j;
            if (n_iss == 0)  first_trip = {DTFAG_i, DTFAG_t, DTFAG_j};
            if (n_iss == 16) trip17     = {DTFAG_i, DTFAG_t, DTFAG_j};
            n_iss++;
            last_iss_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 1, 0);
            end else begin
               req_t e;
               trk_t v;
               e = exp_q.pop_front();
               chk("triple", int'({DTFAG_i, DTFAG_t, DTFAG_j}), int'({e.i, e.t, e.j}));
               v.s = e.s; v.l = e.l; v.cyc = cyc;
               val_q.push_back(v);
            end
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (n_done == 0) chk("done_timeout", 0, 1);
   endtask

   task automatic check_full_run(input string tag);
      repeat (5) @(negedge clk);
      #1;
      chk({tag, "_issues"}, n_iss, TOTAL);
      chk({tag, "_valids"}, n_val, TOTAL);
      chk({tag, "_done_cycles"}, n_done, 1);
      chk({tag, "_done_delay"}, done_cyc - last_iss_cyc, LAT + 1);
      chk({tag, "_first_triple"}, int'(first_trip), 0);
      chk({tag, "_exp_left"}, exp_q.size(), 0);
      chk({tag, "_busy_end"}, int'(busy), 0);
   endtask

   logic [11:0] t17_req;
   logic [3:0]  j8_req;

   initial begin
      rst = 1'b1; start = 1'b0; tf_pop = 1'b0;
      clear_run();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state and idle behaviour
      @(negedge clk);
      chk("rst_indices", int'({DTFAG_i, DTFAG_t, DTFAG_j}), 0);
      chk("rst_stage_last", int'({tf_stage, tf_last}), 0);
      chk("rst_done", int'(done), 0);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("idle_rom_valid_busy", int'({ROM_CEN, tf_valid, busy}), 3'b100);
      end

      // full sequence with continuous pops
      clear_run();
      fill_exp();
      tf_pop = 1'b1;
      pulse_start();
      wait_done(6000);
      check_full_run("run1");
      t17_req = 12'h010;
`ifdef DTFAG_SEQ_BITREV_EN
      t17_req = 12'h010;
      chk("first_j0", int'(first_j[0]), 0);
      chk("first_j1", int'(first_j[1]), 8);
      chk("first_j2", int'(first_j[2]), 4);
      chk("first_j3", int'(first_j[3]), 12);
`else
      chk("first_j0", int'(first_j[0]), 0);
      chk("first_j1", int'(first_j[1]), 1);
      chk("first_j2", int'(first_j[2]), 2);
      chk("first_j3", int'(first_j[3]), 3);
`endif
      chk("triple17", int'(trip17), int'(t17_req));
      chk("last_group0", last_grp[0], 4096);
      chk("last_group1", last_grp[1], 4352);
      chk("last_group2", last_grp[2], 4368);

      // credit exhaustion then a single returned credit
      clear_run();
      fill_exp();
      tf_pop = 1'b0;
      pulse_start();
      repeat (20) @(negedge clk);
      #1;
      chk("credit_issues", n_iss, 8);
      chk("credit_rom_cen", int'(ROM_CEN), 1);
`ifdef DTFAG_SEQ_BITREV_EN
      j8_req = 4'd1;
`else
      j8_req = 4'd8;
`endif
      chk("held_indices", int'({DTFAG_i, DTFAG_t, DTFAG_j}), int'({8'h00, j8_req}));
      chk("credit_busy", int'(busy), 1);
      @(posedge clk); #1 tf_pop = 1'b1;
      @(posedge clk); #1 tf_pop = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("one_pop_issues", n_iss, 9);
      chk("one_pop_valids", n_val, 9);

      // reset at issue 100, then restart from (0,0,0)
      tf_pop = 1'b1;
      begin
         int k;
         k = 0;
         while (n_iss < 100 && k < 500) begin
            @(negedge clk); #1;
            k++;
         end
      end
      chk("issue_at_rst", n_iss, 100);
      rst = 1'b1;
      exp_q.delete();
      val_q.delete();
      @(negedge clk);
      chk("rst_rom_busy_valid", int'({ROM_CEN, busy, tf_valid}), 3'b100);
      @(posedge clk); #1 rst = 1'b0;
      clear_run();
      fill_exp();
      first_trip = 12'hfff;
      pulse_start();
      wait_done(6000);
      check_full_run("run2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
